// File: rtl/ir_fetch_sequencer.sv
// Instruction fetch/decode/execute sequencer for the 16-bit microcoded core.
// Owns the PC, the IR contents and the microstep counter.
module ir_fetch_sequencer #(
    parameter int unsigned            ADDR_W   = 16,
    parameter int unsigned            STEP_W   = 4,
    parameter logic [ADDR_W-1:0]      RESET_PC = 16'h0000
) (
    input  logic              IR_clk,
    input  logic              IR_rst,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       ir_data,
    output logic              ir_wr_en,
    output logic              ir_rd_en,
    output logic [STEP_W-1:0] ustep,
    input  logic              uop_last,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              ustep_ovf
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [STEP_W-1:0] STEP_MAX  = {STEP_W{1'b1}};
    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [STEP_W-1:0] ustep_q, ustep_d;
    logic              ovf_q, ovf_d;

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge IR_clk or posedge IR_rst) begin
        if (IR_rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            ustep_q <= STEP_ZERO;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ustep_q <= ustep_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ustep_d = ustep_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // run is deliberately ignored here so a started read always completes
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_LOAD: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ustep_d = STEP_ZERO;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (jump_en) begin
                    pc_d = jump_addr;
                end else begin
                    pc_d = pc_q;
                end
                if (uop_last) begin
                    ustep_d = STEP_ZERO;
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (run) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (ustep_q == STEP_MAX) begin
                    // Runaway microprogram: abort the instruction rather than wrap.
                    ovf_d   = 1'b1;
                    ustep_d = STEP_ZERO;
                    if (run) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    ustep_d = ustep_q + STEP_W'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_req   = (state_q == ST_FETCH);
    assign ir_wr_en  = (state_q == ST_LOAD);
    assign ir_rd_en  = (state_q == ST_EXEC);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted    = (state_q == ST_HALT);
    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign ir_data   = ir_q;
    assign ustep     = ustep_q;
    assign ustep_ovf = ovf_q;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Scoreboard bench for ir_fetch_sequencer: a memory/control responder feeds
// the DUT while expected fetch addresses and IR words are checked from queues.
module tb_ir_fetch_sequencer;

    logic        IR_clk = 1'b0;
    logic        IR_rst = 1'b1;
    logic        run = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] ir_data;
    logic        ir_wr_en;
    logic        ir_rd_en;
    logic [3:0]  ustep;
    logic        uop_last = 1'b0;
    logic        jump_en = 1'b0;
    logic [15:0] jump_addr = 16'h0000;
    logic        halt_req = 1'b0;
    logic [15:0] pc;
    logic        busy;
    logic        halted;
    logic        ustep_ovf;

    int checks = 0;
    int errors = 0;

    int          ack_delay = 1;
    int          last_step = 99;
    int          jump_step = 99;
    logic        halt_cfg  = 1'b0;
    logic [15:0] rdata_cfg = 16'h0000;
    int          req_cyc   = 0;

    logic [15:0] fetch_q[$];
    logic [15:0] ir_exp_q[$];

    ir_fetch_sequencer #(.ADDR_W(16), .STEP_W(4), .RESET_PC(16'h0000)) dut (
        .IR_clk(IR_clk), .IR_rst(IR_rst), .run(run),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_data(ir_data), .ir_wr_en(ir_wr_en), .ir_rd_en(ir_rd_en), .ustep(ustep),
        .uop_last(uop_last), .jump_en(jump_en), .jump_addr(jump_addr), .halt_req(halt_req),
        .pc(pc), .busy(busy), .halted(halted), .ustep_ovf(ustep_ovf)
    );

    always #5 IR_clk = ~IR_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge IR_clk);
        #2;
    endtask

    // sel: 0 mem_req, 1 ir_wr_en, 2 !busy, 3 halted, 4 ir_rd_en
    task automatic wait_for(input int sel, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            case (sel)
                0: hit = mem_req;
                1: hit = ir_wr_en;
                2: hit = !busy;
                3: hit = halted;
                4: hit = ir_rd_en;
                default: hit = 1'b1;
            endcase
        end
        if (!hit) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Memory and control-module responder; also pops the scoreboard.
    initial begin
        forever begin
            @(negedge IR_clk);
            if (mem_req) req_cyc = req_cyc + 1;
            else req_cyc = 0;
            mem_ack   = mem_req && (req_cyc >= ack_delay);
            mem_rdata = rdata_cfg;
            if (mem_req) begin
                if (fetch_q.size() == 0) begin
                    check_eq("fetch_unexpected", {16'h0000, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    check_eq("fetch_addr", {16'h0000, mem_addr}, {16'h0000, fetch_q[0]});
                    if (mem_ack) void'(fetch_q.pop_front());
                end
            end
            if (ir_wr_en) begin
                if (ir_exp_q.size() == 0) check_eq("ir_unexpected", {16'h0000, ir_data}, 32'hFFFF_FFFF);
                else check_eq("ir_data", {16'h0000, ir_data}, {16'h0000, ir_exp_q.pop_front()});
            end
            uop_last  = ir_rd_en && (int'(ustep) == last_step);
            jump_en   = ir_rd_en && (int'(ustep) == jump_step);
            halt_req  = ir_rd_en && halt_cfg && (int'(ustep) == last_step);
        end
    end

    initial begin
        #1;
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_pc", pc, 16'h0000);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_ir", ir_data, 16'h0000);
        check_eq("rst_ovf", ustep_ovf, 1'b0);
        tick();
        tick();
        IR_rst = 1'b0;

        // Basic instruction with immediate ack, three microsteps.
        rdata_cfg = 16'h1203; last_step = 2; ack_delay = 1;
        fetch_q.push_back(16'h0000); ir_exp_q.push_back(16'h1203);
        fetch_q.push_back(16'h0001); ir_exp_q.push_back(16'h1203);
        run = 1'b1;
        wait_for(0, "s1_req");
        check_eq("s1_addr", mem_addr, 16'h0000);
        tick();
        check_eq("s1_wr", ir_wr_en, 1'b1);
        check_eq("s1_ir", ir_data, 16'h1203);
        check_eq("s1_pc", pc, 16'h0001);
        tick();
        check_eq("s1_wr_once", ir_wr_en, 1'b0);
        check_eq("s1_dec_rd", ir_rd_en, 1'b0);
        check_eq("s1_dec_step", ustep, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("s1_exec_rd", ir_rd_en, 1'b1);
            check_eq("s1_step", ustep, i);
        end
        tick();
        check_eq("s1_next_req", mem_req, 1'b1);
        check_eq("s1_next_addr", mem_addr, 16'h0001);
        run = 1'b0;
        wait_for(2, "s1_idle");
        check_eq("s1_pc_end", pc, 16'h0002);

        // Delayed ack with run dropped mid-handshake.
        ack_delay = 5; rdata_cfg = 16'hA5C3; last_step = 0;
        fetch_q.push_back(16'h0002); ir_exp_q.push_back(16'hA5C3);
        run = 1'b1;
        wait_for(0, "s2_req");
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) run = 1'b0;
            check_eq("s2_req_held", mem_req, 1'b1);
            check_eq("s2_addr_held", mem_addr, 16'h0002);
        end
        tick();
        check_eq("s2_wr", ir_wr_en, 1'b1);
        wait_for(2, "s2_idle");
        check_eq("s2_busy", busy, 1'b0);
        check_eq("s2_req_off", mem_req, 1'b0);
        check_eq("s2_pc", pc, 16'h0003);

        // Branch on step 1, last on step 3.
        ack_delay = 1; rdata_cfg = 16'h1111; last_step = 3; jump_step = 1; jump_addr = 16'h0040;
        fetch_q.push_back(16'h0003); ir_exp_q.push_back(16'h1111);
        fetch_q.push_back(16'h0040); ir_exp_q.push_back(16'h1111);
        run = 1'b1;
        wait_for(4, "s3_exec");
        tick();
        tick();
        check_eq("s3_pc_jump", pc, 16'h0040);
        wait_for(0, "s3_req");
        check_eq("s3_addr", mem_addr, 16'h0040);
        run = 1'b0; jump_step = 99;
        wait_for(2, "s3_idle");
        check_eq("s3_pc_end", pc, 16'h0041);

        // Jump to the top of memory, then fetch there and wrap.
        jump_addr = 16'hFFFF; jump_step = 0; last_step = 0;
        fetch_q.push_back(16'h0041); ir_exp_q.push_back(16'h1111);
        fetch_q.push_back(16'hFFFF); ir_exp_q.push_back(16'h1111);
        run = 1'b1;
        wait_for(1, "s3b_wr");
        wait_for(0, "s3b_req");
        check_eq("s3b_addr", mem_addr, 16'hFFFF);
        run = 1'b0; jump_step = 99;
        wait_for(1, "s3b_wr2");
        check_eq("s3b_wrap", pc, 16'h0000);
        wait_for(2, "s3b_idle");

        // Halt with a same-cycle jump; halt beats run.
        halt_cfg = 1'b1; last_step = 1; jump_step = 1; jump_addr = 16'h0100; rdata_cfg = 16'h7F00;
        fetch_q.push_back(16'h0000); ir_exp_q.push_back(16'h7F00);
        run = 1'b1;
        wait_for(3, "s4_halt");
        check_eq("s4_pc", pc, 16'h0100);
        check_eq("s4_busy", busy, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("s4_no_req", {mem_req, halted}, 2'b01);
        end
        check_eq("s4_pc_frozen", pc, 16'h0100);
        IR_rst = 1'b1;
        #1;
        check_eq("s4_rst_pc", pc, 16'h0000);
        check_eq("s4_rst_halted", halted, 1'b0);
        halt_cfg = 1'b0; jump_step = 99; run = 1'b0;
        tick();
        IR_rst = 1'b0;

        // Microstep overflow with no uop_last.
        last_step = 99; rdata_cfg = 16'h2222;
        fetch_q.push_back(16'h0000); ir_exp_q.push_back(16'h2222);
        fetch_q.push_back(16'h0001); ir_exp_q.push_back(16'h2222);
        run = 1'b1;
        wait_for(4, "s5_exec");
        for (int i = 0; i < 16; i++) begin
            check_eq("s5_step", ustep, i);
            check_eq("s5_ovf_low", ustep_ovf, 1'b0);
            tick();
        end
        check_eq("s5_req", mem_req, 1'b1);
        check_eq("s5_addr", mem_addr, 16'h0001);
        check_eq("s5_ovf", ustep_ovf, 1'b1);
        check_eq("s5_step0", ustep, 4'd0);
        run = 1'b0; last_step = 0;
        wait_for(2, "s5_idle");
        check_eq("s5_ovf_sticky", ustep_ovf, 1'b1);
        check_eq("s5_pc", pc, 16'h0002);

        // Reset in the middle of a fetch.
        ack_delay = 10;
        fetch_q.push_back(16'h0002);
        run = 1'b1;
        wait_for(0, "s6_req");
        tick();
        tick();
        IR_rst = 1'b1;
        #1;
        check_eq("s6_req", mem_req, 1'b0);
        check_eq("s6_busy", busy, 1'b0);
        check_eq("s6_pc", pc, 16'h0000);
        check_eq("s6_ir", ir_data, 16'h0000);
        check_eq("s6_ovf", ustep_ovf, 1'b0);
        fetch_q.delete();
        run = 1'b0;
        tick();
        IR_rst = 1'b0;

        // Reset in the middle of execution, step 2.
        ack_delay = 1; last_step = 5; rdata_cfg = 16'hBEEF;
        fetch_q.push_back(16'h0000); ir_exp_q.push_back(16'hBEEF);
        run = 1'b1;
        wait_for(4, "s7_exec");
        tick();
        tick();
        check_eq("s7_step2", ustep, 4'd2);
        IR_rst = 1'b1;
        #1;
        check_eq("s7_step", ustep, 4'd0);
        check_eq("s7_rd", ir_rd_en, 1'b0);
        check_eq("s7_busy", busy, 1'b0);
        check_eq("s7_pc", pc, 16'h0000);
        check_eq("s7_ir", ir_data, 16'h0000);
        check_eq("sb_fetch_drained", fetch_q.size(), 32'd0);
        check_eq("sb_ir_drained", ir_exp_q.size(), 32'd0);
        run = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_fetch_sequencer.md
Name: ir_fetch_sequencer

Overview:
Fetch/decode/execute sequencer for the instruction register of the 16-bit microcoded processor. It fetches instruction words from memory over a req/ack handshake, writes them into the IR, and then steps the microinstruction counter. The IR upper byte (opcode) concatenated with the counter addresses the control ROM. It also owns the program counter and applies branches and halt signalled by the control module.

Parameters:
ADDR_W, 16, width of program counter / memory address
STEP_W, 4, width of microstep counter (max 2^STEP_W steps per instruction)
RESET_PC, 16'h0000, program counter value after reset

Ports:
IR_clk  in  1  clock, all state on rising edge
IR_rst  in  1  asynchronous active-high reset
run  in  1  enable instruction fetching
mem_req  out  1  instruction read request
mem_addr  out  ADDR_W  fetch address (equals pc while mem_req high)
mem_ack  in  1  read complete; mem_rdata valid same cycle
mem_rdata  in  16  fetched instruction word
ir_data  out  16  data to IR_in
ir_wr_en  out  1  IR write strobe
ir_rd_en  out  1  IR full-read enable (low = only opcode byte visible)
ustep  out  STEP_W  microstep index to control ROM address low bits
uop_last  in  1  current microinstruction is the last of the instruction
jump_en  in  1  branch taken (valid in EXEC only)
jump_addr  in  ADDR_W  branch target
halt_req  in  1  halt opcode executing (valid in EXEC only)
pc  out  ADDR_W  program counter
busy  out  1  state != IDLE and != HALT
halted  out  1  high in HALT
ustep_ovf  out  1  sticky: microstep counter overflowed

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, ir_data=0, ustep=0, ustep_ovf=0; mem_req, ir_wr_en, ir_rd_en, busy, halted all 0. Reset mid-handshake drops mem_req at once. Any late mem_ack is ignored because it is sampled only in FETCH.
- Outputs mem_req, ir_wr_en, ir_rd_en, busy, halted are Moore decodes of state. mem_addr=pc.
- IDLE: run=1 at an edge -> FETCH.
- FETCH: mem_req=1. mem_addr and mem_req stay stable until mem_ack is sampled high.
  - On ack: ir_data<=mem_rdata; pc<=pc+1 (wraps modulo 2^ADDR_W); -> LOAD.
  - run falling during FETCH does not abort the handshake.
- LOAD: ir_wr_en=1 for exactly one cycle with ir_data stable -> DECODE.
- DECODE: one cycle; ir_rd_en=0; ustep=0 (opcode byte addresses control ROM step 0) -> EXEC.
- EXEC: ir_rd_en=1. Each edge:
  - jump_en=1: pc<=jump_addr. Overrides the earlier increment; last assertion wins.
  - uop_last=1: ustep<=0.
    - halt_req=1 -> HALT. Halt has priority over run; a same-cycle jump still updates pc.
    - else run=1 -> FETCH.
    - else -> IDLE.
  - uop_last=0 and ustep<2^STEP_W-1: ustep<=ustep+1.
  - uop_last=0 and ustep==2^STEP_W-1: ustep_ovf<=1, ustep<=0, instruction forcibly terminated -> FETCH if run, else IDLE. No wrap into step 0 of the same instruction.
- HALT: all strobes 0, halted=1, pc frozen. Left only via IR_rst.
- jump_en/halt_req are ignored outside EXEC.
- Minimum instruction time: FETCH (1 cycle with immediate ack) + LOAD + DECODE + N EXEC cycles = N+3 cycles.

Test Plan:
- Reset then run=1, mem_ack tied high, mem_rdata=16'h1203, uop_last high on step 2 -> mem_req 1 cycle at addr 0; ir_wr_en 1 cycle with ir_data=16'h1203; ustep 0,1,2; pc=1; next FETCH at addr 1.
- mem_ack delayed 5 cycles, run dropped on cycle 2 -> mem_req/mem_addr held 5 cycles; instruction completes; state IDLE afterwards, busy=0.
- jump_en with jump_addr=16'h0040 on EXEC step 1, uop_last on step 3 -> next mem_addr=16'h0040. Also pc=16'hFFFF fetch -> pc wraps to 0.
- halt_req with uop_last -> halted=1, no further mem_req for 20 cycles despite run=1. Assert IR_rst -> pc=0, halted=0.
- uop_last never asserted (STEP_W=4) -> ustep counts 0..15, ustep_ovf=1, then FETCH of next address; ustep_ovf stays 1 until reset.
- IR_rst asserted mid-FETCH and mid-EXEC (step 2) -> all outputs return to reset values asynchronously, before the next clock edge.
